// File: rtl/sensor_sample_buffer_pkg.sv
`default_nettype none
// sensor_sample_buffer_pkg: shared sizes and IRQ state encoding for the sensor sample buffer.
// Rev 1.0. ENTRY_W widens to 32 when SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN is defined.
package sensor_sample_buffer_pkg;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 16;
`ifdef SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN
  localparam int TS_W    = 16;
  localparam int ENTRY_W = DATA_W + TS_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } irq_state_t;
endpackage
`default_nettype wire

// File: rtl/sample_ring_ram.sv
`default_nettype none
// sample_ring_ram: DEPTH-entry register array, synchronous write, asynchronous read.
// Rev 1.0. Contents are deliberately not reset.
module sample_ring_ram
  import sensor_sample_buffer_pkg::*;
#(
  parameter int WIDTH = ENTRY_W
) (
  input  logic             Clk_i,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/sensor_sample_buffer.sv
`default_nettype none
// sensor_sample_buffer: 8-entry first-word-fall-through sample ring with overflow flag and level IRQ.
// Rev 1.0. Optional SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN adds a tick counter and Timestamp_o.
module sensor_sample_buffer
  import sensor_sample_buffer_pkg::*;
(
  input  logic              Clk_i,
  input  logic              Reset_n_i,
  input  logic              Enable_i,
  input  logic              Store_i,
  input  logic [DATA_W-1:0] Value_i,
  input  logic              ReadNext_i,
  output logic [DATA_W-1:0] Data_o,
  output logic [CNT_W-1:0]  Count_o,
  output logic              Empty_o,
  output logic              Full_o,
  output logic              Overflow_o,
  input  logic              ClearOvfl_i,
  input  logic [CNT_W-1:0]  IrqLevel_i,
`ifdef SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN
  output logic [TS_W-1:0]   Timestamp_o,
`endif
  output logic              Irq_o,
  input  logic              IrqAck_i
);
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovfl;
  irq_state_t         r_irq_state, w_irq_next;
  logic               w_full, w_empty, w_store, w_read, w_pop, w_ovfl_set;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;

  assign w_full  = (r_count == c_FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_store = Enable_i & Store_i;
  assign w_read  = Enable_i & ReadNext_i & ~w_empty;
  // A store into a full ring without a pop discards the oldest entry.
  assign w_pop      = w_read | (w_store & w_full);
  assign w_ovfl_set = w_store & w_full & ~w_read;

`ifdef SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN
  logic [TS_W-1:0] r_tick;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i)    r_tick <= '0;
    else if (Enable_i) r_tick <= r_tick + 1'b1;
  end

  assign w_wdata     = {r_tick, Value_i};
  assign Timestamp_o = w_empty ? '0 : w_rdata[ENTRY_W-1:DATA_W];
`else
  assign w_wdata = Value_i;
`endif

  sample_ring_ram #(.WIDTH(ENTRY_W)) u_ram (
    .Clk_i   (Clk_i),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!Enable_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_store && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_store) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i)       r_ovfl <= 1'b0;
    else if (ClearOvfl_i) r_ovfl <= 1'b0;
    else if (w_ovfl_set)  r_ovfl <= 1'b1;
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) r_irq_state <= IDLE;
    else            r_irq_state <= w_irq_next;
  end

  // Levels above DEPTH stay ARMED forever because Count can never reach them.
  always_comb begin
    w_irq_next = r_irq_state;
    if (IrqLevel_i == '0) begin
      w_irq_next = IDLE;
    end else begin
      case (r_irq_state)
        IDLE:    if (r_count < IrqLevel_i)  w_irq_next = ARMED;
        ARMED:   if (r_count >= IrqLevel_i) w_irq_next = PENDING;
        PENDING: if (IrqAck_i)              w_irq_next = IDLE;
        default: w_irq_next = IDLE;
      endcase
    end
  end

  assign Data_o     = w_empty ? '0 : w_rdata[DATA_W-1:0];
  assign Count_o    = r_count;
  assign Empty_o    = w_empty;
  assign Full_o     = w_full;
  assign Overflow_o = r_ovfl;
  assign Irq_o      = (r_irq_state == PENDING);
endmodule
`default_nettype wire

// File: doc/sensor_sample_buffer.md
SENSOR_SAMPLE_BUFFER -- requirements
Module: sensor_sample_buffer

Interface
REQ-001 The block SHALL have port Clk_i, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port Reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port Enable_i, input, 1 bit: buffer enable; low flushes the buffer and blocks stores.
REQ-004 The block SHALL have port Store_i, input, 1 bit: one-cycle strobe from the SensorFSM store-new-value output.
REQ-005 The block SHALL have port Value_i, input, 16 bits: sensor word from the Byte2Word assembly (high byte first).
REQ-006 The block SHALL have port ReadNext_i, input, 1 bit: CPU pop strobe.
REQ-007 The block SHALL have port Data_o, output, 16 bits: oldest stored sample (first-word fall-through).
REQ-008 The block SHALL have port Count_o, output, 4 bits: number of stored samples, 0..8.
REQ-009 The block SHALL have ports Empty_o and Full_o, output, 1 bit each: Count_o==0 and Count_o==8 respectively.
REQ-010 The block SHALL have port Overflow_o, output, 1 bit: sticky flag, set when a sample was discarded.
REQ-011 The block SHALL have port ClearOvfl_i, input, 1 bit: clears Overflow_o.
REQ-012 The block SHALL have port IrqLevel_i, input, 4 bits: fill level that raises the interrupt; 0 disables it.
REQ-013 The block SHALL have port Irq_o, output, 1 bit: CPU interrupt, held high until acknowledged.
REQ-014 The block SHALL have port IrqAck_i, input, 1 bit: interrupt acknowledge.

Function
REQ-015 Storage SHALL be an 8-entry ring with 3-bit write and read pointers that wrap 7->0.
REQ-016 A store with Enable_i=1 and Count<8 SHALL write Value_i at the write pointer, advance the pointer and increment Count, all in one cycle.
REQ-017 A store while Full SHALL overwrite the oldest entry, advance both pointers, keep Count=8 and set Overflow_o on the next edge.
REQ-018 ReadNext_i with Count>0 SHALL advance the read pointer and decrement Count.
REQ-019 ReadNext_i while Empty SHALL be ignored, with no state change.
REQ-020 Simultaneous Store_i and ReadNext_i while Full SHALL pop and push, keep Count=8 and leave Overflow_o unchanged.
REQ-021 Simultaneous Store_i and ReadNext_i while Empty SHALL ignore the read and set Count=1.
REQ-022 Simultaneous Store_i and ReadNext_i with 0<Count<8 SHALL leave Count unchanged.
REQ-023 Data_o SHALL equal the entry at the read pointer when not empty and 16'h0000 when empty, with zero-cycle latency from the pointer update.
REQ-024 A written sample SHALL appear on Data_o the cycle after Store_i if the buffer was empty.
REQ-025 Enable_i=0 SHALL zero Count and both pointers on the next edge; Overflow_o and the IRQ FSM SHALL be kept.
REQ-026 When set and clear of Overflow_o coincide, ClearOvfl_i SHALL win.
REQ-027 The IRQ FSM SHALL have states IDLE, ARMED and PENDING.
REQ-028 IRQ transition IDLE->ARMED SHALL occur when IrqLevel_i!=0 and Count<IrqLevel_i.
REQ-029 IRQ transition ARMED->PENDING SHALL occur when Count>=IrqLevel_i.
REQ-030 IRQ transition PENDING->IDLE SHALL occur on IrqAck_i.
REQ-031 IrqLevel_i=0 SHALL force the IRQ FSM to IDLE from any state.
REQ-032 Irq_o SHALL be 1 exactly while in PENDING.
REQ-033 IrqLevel_i values above 8 SHALL never trigger the interrupt.

Reset
REQ-034 Reset SHALL force pointers=0, Count_o=0, Empty_o=1, Full_o=0, Overflow_o=0, Irq_o=0, IRQ FSM=IDLE and Data_o=0.
REQ-035 Memory contents SHALL not be reset.
REQ-036 Reset asserted mid-operation SHALL discard all samples immediately, without waiting for a clock edge.

Configuration
REQ-037 With macro SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN defined, the block SHALL run a 16-bit free-running tick counter that increments each cycle while Enable_i=1, wraps FFFF->0000 and resets to 0.
REQ-038 With SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN defined, each entry SHALL store the counter value alongside the sample, and an extra output Timestamp_o (16 bits) SHALL present the timestamp of the Data_o entry (0 when empty).
REQ-039 With SENSOR_SAMPLE_BUFFER_TIMESTAMP_EN undefined, the counter, the timestamp storage and the Timestamp_o port SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-040 Shared package sensor_sample_buffer_pkg SHALL hold DEPTH=8, PTR_W=3, CNT_W=4, DATA_W=16 and the IRQ state enum (IDLE, ARMED, PENDING).
REQ-041 One sub-module, sample_ring_ram, SHALL hold the 8xDATA_W (or 8x32 with timestamps) register array with a synchronous write port and an asynchronous read port.
REQ-042 The pointer, count and IRQ logic SHALL remain in the top level.

Verification
REQ-043 Bench SHALL cover: store 1234h, 5678h, 9ABCh -> Count=3, Data_o=1234h; pop -> Data_o=5678h, Count=2.
REQ-044 Bench SHALL cover: 9 stores of values 1..9 -> Full=1, Count=8, Overflow_o=1, Data_o=0002h; ClearOvfl_i -> Overflow_o=0.
REQ-045 Bench SHALL cover: when Full, Store_i=AAAAh together with ReadNext_i -> Count=8, Overflow_o=0, Data_o advances one entry, and AAAAh is the last entry popped.
REQ-046 Bench SHALL cover: when Empty, ReadNext_i -> no change; Store_i with ReadNext_i -> Count=1, Data_o=stored value.
REQ-047 Bench SHALL cover: IrqLevel_i=3 and three stores -> Irq_o rises the cycle after Count reaches 3; a fourth store keeps Irq_o=1; IrqAck_i -> Irq_o=0; pop to Count=2 and refill to 3 -> Irq_o=1 again.
REQ-048 Bench SHALL cover: Reset_n_i pulsed low with Count=5 -> all outputs at reset values asynchronously; Enable_i=0 with Count=4 -> Count=0 next cycle and Store_i ignored while low.
